// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch block.
package fetch_pkg;

    // Bytes per instruction; the sequential PC step.
    localparam int INSTR_BYTES = 4;

    // Fetch controller state: IDLE has no request in flight, WAIT has one.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } fetch_state_t;

    // Width of one buffered {pc, instruction} entry.
    function automatic int entry_w(input int addr_w, input int data_w);
        return addr_w + data_w;
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO of fetched {pc, instruction} entries with a one-cycle flush.
module fetch_buf #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;

    // Storage, pointers and occupancy; flush overrides any push or pop.
    // NOTE: the two storage words are reset so inst_pc/inst_data read 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: drives the PC register, issues one-at-a-time memory reads
// under a two-credit limit, and queues tagged instructions for decode.
module instr_fetch
    import fetch_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    output logic              pc_load,
    output logic [ADDR_W-1:0] pc_next,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [DATA_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc
);

    localparam int                ENTRY_W = entry_w(ADDR_W, DATA_W);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(INSTR_BYTES);

    fetch_state_t        state;
    fetch_state_t        state_next;
    logic                drop;
    logic                drop_next;
    logic [ADDR_W-1:0]   tag;
    logic [ADDR_W-1:0]   tag_next;
    logic                active;
    logic [1:0]          count;
    logic [ENTRY_W-1:0]  head;
    logic [ADDR_W-1:0]   fetch_addr;
    logic                outstanding;
    logic                credit_ok;
    logic                req_fire;
    logic                rsp_accept;
    logic                pop;

    // Word-aligned fetch address taken straight from the PC register.
    assign fetch_addr  = {pc_in[ADDR_W-1:2], 2'b00};
    assign outstanding = (state == WAIT);
    // Buffered entries plus the in-flight request may never exceed the buffer size.
    assign credit_ok   = (int'(count) + int'(outstanding)) < BUF_DEPTH;

    // active holds every output quiet while reset is applied and for the first edge after release.
    assign imem_req_valid = active && (state == IDLE) && credit_ok && !redirect_valid;
    assign imem_req_addr  = imem_req_valid ? fetch_addr : '0;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign pc_load        = active && (redirect_valid || req_fire);
    assign rsp_accept     = outstanding && !drop && imem_rsp_valid;
    assign inst_valid     = (count != 2'd0);
    assign pop            = inst_valid && inst_ready;

    // PC update value: a redirect target beats the sequential +4 step.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        pc_next = '0;
        if (active && redirect_valid) begin
            pc_next = redirect_pc;
        end else if (req_fire) begin
            pc_next = pc_in + PC_STEP;
        end
    end

    // Next-state logic: accept moves to WAIT, any response returns to IDLE and
    // a redirect with no response this cycle marks the pending one for discard.
    always_comb begin
        state_next = state;
        drop_next  = drop;
        tag_next   = tag;
        case (state)
            IDLE: begin
                if (req_fire) begin
                    state_next = WAIT;
                    tag_next   = fetch_addr;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    state_next = IDLE;
                    drop_next  = 1'b0;
                end else if (redirect_valid) begin
                    drop_next = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                drop_next  = 1'b0;
            end
        endcase
    end

    // Controller registers; reset also abandons any request still in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            drop   <= 1'b0;
            tag    <= '0;
            active <= 1'b0;
        end else begin
            state  <= state_next;
            drop   <= drop_next;
            tag    <= tag_next;
            active <= 1'b1;
        end
    end

    // A redirect flushes the buffer and wins over a same-cycle response write.
    fetch_buf #(
        .W(ENTRY_W)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst),
        .flush     (redirect_valid),
        .push      (rsp_accept),
        .push_data ({tag, imem_rsp_data}),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    assign inst_pc   = head[ENTRY_W-1 -: ADDR_W];
    assign inst_data = head[DATA_W-1:0];

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Reader side of the program-counter register. Each cycle it samples the current PC, issues instruction-memory reads, and drives the PC load/next-value pair.
- Returned instructions, tagged with their PC, are buffered in a 2-entry queue and handed to decode over a valid/ready handshake.
- Sits between the PC register, the instruction memory port and the decode stage. Handles branch/jump redirects and flushes.

Parameters:
- ADDR_W, 32, PC and memory address width.
- DATA_W, 32, instruction width.
- BUF_DEPTH, 2, output buffer entries. Fixed at 2; the credit logic depends on it.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- pc_in  in  ADDR_W  current PC register value.
- pc_load  out  1  load enable to PC register.
- pc_next  out  ADDR_W  value PC loads when pc_load=1.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  ADDR_W  redirect target.
- imem_req_valid  out  1  read request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  ADDR_W  read address.
- imem_rsp_valid  in  1  one-cycle response pulse; no backpressure.
- imem_rsp_data  in  DATA_W  instruction word.
- inst_valid  out  1  instruction available to decode.
- inst_ready  in  1  decode accepts instruction.
- inst_data  out  DATA_W  instruction.
- inst_pc  out  ADDR_W  PC of inst_data.

Behaviour:
- Reset (rst=0, immediate): state IDLE, buffer empty, outstanding=0, drop=0.
  - All outputs 0: imem_req_valid, pc_load, pc_next, imem_req_addr, inst_valid, inst_data, inst_pc.
- FSM has two states:
  - IDLE: no request outstanding.
  - WAIT: one request accepted, response pending.
  - At most one outstanding request.
- Credit rule: imem_req_valid=1 only in IDLE, when buffer count + outstanding < 2, and when redirect_valid=0.
- Address: imem_req_addr = {pc_in[ADDR_W-1:2], 2'b00}. It is combinational from pc_in and stays stable while imem_req_valid=1 and imem_req_ready=0.
- Request handshake (valid & ready):
  - Same cycle: pc_load=1, pc_next=pc_in+4, with wrap at 2^ADDR_W.
  - Next cycle: state WAIT; the request's PC is latched as the tag.
- Response:
  - Accepted only in WAIT and only if drop=0.
  - {tag, imem_rsp_data} is written to the buffer; state returns to IDLE.
  - Earliest response: 1 cycle after acceptance.
  - inst_valid rises the cycle after the response (registered).
- Response in IDLE (no outstanding request): ignored.
- Redirect (redirect_valid=1):
  - Same cycle: pc_load=1, pc_next=redirect_pc. Redirect has priority over +4.
  - Buffer is flushed at the next edge.
  - If in WAIT, drop is set; the pending response is discarded and clears drop, returning to IDLE.
  - A request is not issued in the redirect cycle.
  - A buffer write and a redirect in the same cycle: the flush wins.
- Buffer: 2-entry FIFO of {pc, instr}. Head drives inst_pc and inst_data.
  - Simultaneous push and pop when count=2 cannot occur, because the credit rule prevents it.
  - Simultaneous push and pop at count=1 keeps count=1.
- pc_load=0 in every other cycle. Fetch throughput is 1 instruction per 2 cycles minimum.
- Reset during WAIT: outstanding state is cleared; a late response after reset is ignored, since the block is in IDLE.

Decomposition:
- Package fetch_pkg:
  - INSTR_BYTES=4.
  - Fetch state encoding IDLE=1'b0, WAIT=1'b1.
  - Buffer entry width ADDR_W+DATA_W.
- One sub-module: fetch_buf, a 2-entry synchronous FIFO with flush, count, push/pop, and active-low asynchronous reset.

Test Plan:
- Basic fetch:
  - Stimulus: PC model reset 0; imem ready=1; response 1 cycle after accept; inst_ready=1.
  - Required: requests at 0x0, 0x4, 0x8; pc_load pulses with pc_next 0x4, 0x8, 0xC; inst_pc/inst_data match the memory image in order.
- Backpressure:
  - Stimulus: inst_ready=0.
  - Required: after 2 instructions buffered (pc 0x0, 0x4), imem_req_valid stays 0 and PC holds 0x8. After raising inst_ready, 0x0 is delivered first and a request to 0x8 resumes.
- Memory stall:
  - Stimulus: imem_req_ready=0 for 3 cycles at pc 0x10.
  - Required: imem_req_valid=1 and addr 0x10 held stable; pc_load=0 throughout; single pc_load on the accept cycle.
- Redirect during WAIT:
  - Stimulus: redirect_pc=0x100 while the 0x20 response is pending.
  - Required: 0x20 response dropped; buffer flushed; next request addr 0x100; next inst_pc 0x100.
- Redirect plus buffer write:
  - Stimulus: redirect to 0x200 in the same cycle a response arrives.
  - Required: that instruction is never presented; pc_next=0x200.
- Reset mid-WAIT:
  - Stimulus: rst=0 asynchronously, then a response pulse 1 cycle after release.
  - Required: all outputs 0 immediately; stale response ignored; first request after reset uses pc_in=0.
